mem_ctrl: RTL and testbench

- Memory controller at the far end of the MEM→WB load handshake.
- Arbitrates instruction-fetch and data-access requests onto a single byte-wide synchronous RAM, and serialises 1/2/4-byte little-endian transfers.
- Returns a one-cycle mmem_finished pulse with an assembled, extended 32-bit mmem_data word. These feed mem_wb directly.
- Raises stall_req while any transaction is outstanding.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_ext.sv | 28 ++
 rtl/mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the byte-serial memory controller:
//   - transfer width codes (byte / half / word)
//   - controller state encoding
//   - default RAM byte-address width
//   - helper that maps a width code to its byte count
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int RAM_AW_DEFAULT = 17;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'b00,
        MC_READ  = 2'b01,
        MC_WRITE = 2'b10,
        MC_DONE  = 2'b11
    } mc_state_t;

    // Width code 2'b11 is treated as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// mem_ext
// Combinational load-result formatter. Takes the four assembled byte
// lanes (lane 0 = lowest address, little-endian) and produces the
// 32-bit result, sign- or zero-extending byte and half loads.
// Ports:
//   width  in  2   transfer width code
//   sext   in  1   sign-extend enable for byte/half
//   lanes  in  32  assembled lanes {lane3, lane2, lane1, lane0}
//   data   out 32  extended result
module mem_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        sext,
    input  logic [31:0] lanes,
    output logic [31:0] data
);

    always_comb begin
        data = lanes;
        case (width)
            MEM_BYTE: data = {{24{sext & lanes[7]}}, lanes[7:0]};
            MEM_HALF: data = {{16{sext & lanes[15]}}, lanes[15:0]};
            default:  data = lanes;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Arbitrates instruction-fetch and data requests onto one byte-wide
// synchronous RAM, serialising 1/2/4-byte little-endian transfers.
// Data requests win over fetches when both are pending in IDLE; an
// in-flight transaction is never preempted.
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch request (level-held)
//   if_done/if_inst               fetch completion pulse and word
//   mem_req/we/width/sext/addr/wdata  data request (level-held)
//   mmem_finished/mmem_data       data completion pulse and result
//   stall_req                     pipeline stall request
//   ram_a/ram_wr/ram_dout/ram_din byte RAM interface (1-cycle read)
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic              mem_sext,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mmem_finished,
    output logic [31:0]       mmem_data,
    output logic              stall_req,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    mc_state_t         state;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [RAM_AW-1:0] addr_q;
    logic [1:0]        width_q;
    logic              sext_q;
    logic              we_q;
    logic              fetch_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lanes_q;
    logic [31:0]       ext_data;
    logic [1:0]        cap_lane;
    logic [1:0]        next_lane;

    // Upper request address bits fall outside the RAM and are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

    // The byte arriving on ram_din belongs to the address issued one
    // cycle earlier, so captures trail the counter by one lane.
    assign cap_lane  = cnt[1:0] - 2'd1;
    assign next_lane = cnt[1:0] + 2'd1;

    assign stall_req = ((state != MC_IDLE) | mem_req | if_req) & (state != MC_DONE);

    mem_ext u_ext (
        .width (width_q),
        .sext  (sext_q),
        .lanes (lanes_q),
        .data  (ext_data)
    );

    // Controller FSM. The completion pulse is registered out of DONE,
    // so it appears in the cycle after DONE, with the RAM already idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MC_IDLE;
            cnt           <= 3'd0;
            nbytes        <= 3'd0;
            addr_q        <= '0;
            width_q       <= MEM_BYTE;
            sext_q        <= 1'b0;
            we_q          <= 1'b0;
            fetch_q       <= 1'b0;
            wdata_q       <= 32'd0;
            lanes_q       <= 32'd0;
            if_done       <= 1'b0;
            if_inst       <= 32'd0;
            mmem_finished <= 1'b0;
            mmem_data     <= 32'd0;
            ram_a         <= '0;
            ram_wr        <= 1'b0;
            ram_dout      <= 8'd0;
        end else begin
            if_done       <= 1'b0;
            mmem_finished <= 1'b0;
            case (state)
                MC_IDLE: begin
                    cnt     <= 3'd0;
                    lanes_q <= 32'd0;
                    if (mem_req) begin
                        addr_q  <= mem_addr[RAM_AW-1:0];
                        width_q <= mem_width;
                        sext_q  <= mem_sext;
                        we_q    <= mem_we;
                        fetch_q <= 1'b0;
                        wdata_q <= mem_wdata;
                        nbytes  <= byte_count(mem_width);
                        ram_a   <= mem_addr[RAM_AW-1:0];
                        if (mem_we) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                            state    <= MC_WRITE;
                        end else begin
                            state    <= MC_READ;
                        end
                    end else if (if_req) begin
                        addr_q  <= if_addr[RAM_AW-1:0];
                        width_q <= MEM_WORD;
                        sext_q  <= 1'b0;
                        we_q    <= 1'b0;
                        fetch_q <= 1'b1;
                        nbytes  <= 3'd4;
                        ram_a   <= if_addr[RAM_AW-1:0];
                        state   <= MC_READ;
                    end
                end
                MC_READ: begin
                    if (cnt != 3'd0) begin
                        lanes_q[{cap_lane, 3'b000} +: 8] <= ram_din;
                    end
                    if (cnt == nbytes) begin
                        state <= MC_DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if ((cnt + 3'd1) < nbytes) begin
                            ram_a <= addr_q + RAM_AW'(cnt + 3'd1);
                        end
                    end
                end
                MC_WRITE: begin
                    if (cnt == (nbytes - 3'd1)) begin
                        ram_wr <= 1'b0;
                        state  <= MC_DONE;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        ram_a    <= addr_q + RAM_AW'(cnt + 3'd1);
                        ram_dout <= wdata_q[{next_lane, 3'b000} +: 8];
                    end
                end
                MC_DONE: begin
                    if (fetch_q) begin
                        if_done <= 1'b1;
                        if_inst <= lanes_q;
                    end else begin
                        mmem_finished <= 1'b1;
                        mmem_data     <= we_q ? 32'd0 : ext_data;
                    end
                    cnt   <= 3'd0;
                    state <= MC_IDLE;
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Directed bench for mem_ctrl with a behavioural byte RAM (one-cycle
// read latency). Expected values are hand-computed constants.
module tb_mem_ctrl;

    localparam int AW = 17;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_done;
    logic [31:0]   if_inst;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_width;
    logic          mem_sext;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mmem_finished;
    logic [31:0]   mmem_data;
    logic          stall_req;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram [0:(1<<AW)-1];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [7:0]    tb_data;

    int            compared;
    int            mismatched;
    logic [AW-1:0] wr_addr [4];
    logic [7:0]    wr_byte [4];

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .if_inst       (if_inst),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_width     (mem_width),
        .mem_sext      (mem_sext),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mmem_finished (mmem_finished),
        .mmem_data     (mmem_data),
        .stall_req     (stall_req),
        .ram_a         (ram_a),
        .ram_wr        (ram_wr),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte RAM: synchronous write, read data valid the cycle after the
    // address; a bench-side port is used for preloading.
    always @(posedge clk) begin
        if (tb_we) ram[tb_addr] <= tb_data;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pokeByte(input logic [AW-1:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Issue one data request, wait (bounded) for mmem_finished, and log
    // any RAM writes seen on the way. Latency counts edges after accept.
    task automatic applyStimulus(input logic we, input logic [1:0] width, input logic sext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] data, output int nwr);
        mem_req = 1'b1;
        mem_we = we;
        mem_width = width;
        mem_sext = sext;
        mem_addr = addr;
        mem_wdata = wdata;
        nwr = 0;
        lat = 0;
        data = 32'hxxxxxxxx;
        @(posedge clk); #1;
        while (!mmem_finished && lat < 20) begin
            if (ram_wr) begin
                if (nwr < 4) begin
                    wr_addr[nwr] = ram_a;
                    wr_byte[nwr] = ram_dout;
                end
                nwr++;
            end
            @(posedge clk); #1;
            lat++;
        end
        data = mmem_data;
        mem_req = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic fetchWord(input logic [31:0] addr, output int lat, output logic [31:0] inst);
        if_req = 1'b1;
        if_addr = addr;
        lat = 0;
        @(posedge clk); #1;
        while (!if_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        inst = if_inst;
        if_req = 1'b0;
    endtask

    initial begin
        int lat;
        int nwr;
        int cyc;
        int fin_cyc;
        int done_cyc;
        int stall_low;
        int pulses;
        logic [31:0] data;
        logic [31:0] inst;
        logic [31:0] held;

        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_data = 8'd0;
        if_req = 1'b0;
        if_addr = 32'd0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_width = 2'b00;
        mem_sext = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_if_done", {31'd0, if_done}, 32'd0);
        checkOutput("rst_mmem_finished", {31'd0, mmem_finished}, 32'd0);
        checkOutput("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        checkOutput("rst_ram_a", {15'd0, ram_a}, 32'd0);
        checkOutput("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        checkOutput("rst_if_inst", if_inst, 32'd0);
        checkOutput("rst_mmem_data", mmem_data, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        pokeByte(17'h00100, 8'h78);
        pokeByte(17'h00101, 8'h56);
        pokeByte(17'h00102, 8'h34);
        pokeByte(17'h00103, 8'h12);
        pokeByte(17'h00020, 8'h80);
        pokeByte(17'h00021, 8'hFF);
        pokeByte(17'h00040, 8'h00);
        pokeByte(17'h00041, 8'h00);
        pokeByte(17'h00042, 8'h5A);
        for (int i = 0; i < 4; i++) pokeByte(17'h00200 + 17'(i), 8'h00);
        pokeByte(17'h1FFFE, 8'h11);
        pokeByte(17'h1FFFF, 8'h22);
        pokeByte(17'h00000, 8'h33);
        pokeByte(17'h00001, 8'h44);

        $display("[TB] word load");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00000100, 32'd0, lat, data, nwr);
        checkOutput("wload_lat", lat, 6);
        checkOutput("wload_data", data, 32'h12345678);
        checkOutput("wload_nwr", nwr, 0);

        $display("[TB] byte and half loads");
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h00000020, 32'd0, lat, data, nwr);
        checkOutput("lb_lat", lat, 3);
        checkOutput("lb_data", data, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h00000020, 32'd0, lat, data, nwr);
        checkOutput("lbu_data", data, 32'h00000080);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h00000020, 32'd0, lat, data, nwr);
        checkOutput("lh_lat", lat, 4);
        checkOutput("lh_data", data, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h00000020, 32'd0, lat, data, nwr);
        checkOutput("lhu_data", data, 32'h0000FF80);
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h00000100, 32'd0, lat, data, nwr);
        checkOutput("w11_lat", lat, 6);
        checkOutput("w11_data", data, 32'h12345678);

        $display("[TB] half store");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h00000040, 32'hDEADBEEF, lat, data, nwr);
        checkOutput("sh_lat", lat, 3);
        checkOutput("sh_nwr", nwr, 2);
        checkOutput("sh_a0", {15'd0, wr_addr[0]}, 32'h40);
        checkOutput("sh_d0", {24'd0, wr_byte[0]}, 32'hEF);
        checkOutput("sh_a1", {15'd0, wr_addr[1]}, 32'h41);
        checkOutput("sh_d1", {24'd0, wr_byte[1]}, 32'hBE);
        checkOutput("sh_data", data, 32'd0);
        checkOutput("sh_ram42", {24'd0, ram[17'h42]}, 32'h5A);

        $display("[TB] arbitration");
        @(posedge clk); #1;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_width = 2'b00;
        mem_sext = 1'b0;
        mem_addr = 32'h00000020;
        if_req = 1'b1;
        if_addr = 32'h00000100;
        @(posedge clk); #1;
        cyc = 0;
        fin_cyc = -1;
        done_cyc = -1;
        stall_low = 0;
        data = 32'd0;
        inst = 32'd0;
        while (done_cyc < 0 && cyc < 40) begin
            if (!stall_req) stall_low++;
            if (mmem_finished) begin
                fin_cyc = cyc;
                data = mmem_data;
                mem_req = 1'b0;
            end
            if (if_done) begin
                done_cyc = cyc;
                inst = if_inst;
                if_req = 1'b0;
            end
            if (done_cyc < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        checkOutput("arb_fin_cyc", fin_cyc, 3);
        checkOutput("arb_done_cyc", done_cyc, 10);
        checkOutput("arb_stall_low", stall_low, 2);
        checkOutput("arb_data", data, 32'h00000080);
        checkOutput("arb_inst", inst, 32'h12345678);

        $display("[TB] reset during word store");
        @(posedge clk); #1;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_width = 2'b10;
        mem_sext = 1'b0;
        mem_addr = 32'h00000200;
        mem_wdata = 32'hA1B2C3D4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rw_byte1_wr", {31'd0, ram_wr}, 32'd1);
        checkOutput("rw_byte1_a", {15'd0, ram_a}, 32'h201);
        rst = 1'b1;
        mem_req = 1'b0;
        mem_we = 1'b0;
        #1;
        checkOutput("rw_wr_drop", {31'd0, ram_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rw_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("rw_ram200", {24'd0, ram[17'h200]}, 32'hD4);
        checkOutput("rw_ram201", {24'd0, ram[17'h201]}, 32'h00);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (mmem_finished || ram_wr) pulses++;
            @(posedge clk); #1;
        end
        checkOutput("rw_no_pulse", pulses, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h00000100, 32'd0, lat, data, nwr);
        checkOutput("rw_fresh_lat", lat, 6);
        checkOutput("rw_fresh_data", data, 32'h12345678);
        held = data;

        $display("[TB] address wrap fetch");
        fetchWord(32'hFFFFFFFE, lat, inst);
        checkOutput("wrap_lat", lat, 6);
        checkOutput("wrap_inst", inst, 32'h44332211);
        checkOutput("wrap_mdata_held", mmem_data, held);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
